// File: rtl/ov_frame_capture.sv
// ov_frame_capture: OV7670 capture stage with internal decimated RGB565 frame RAM.
//
// The camera pins (pclk, vsync, href, data) are synchronised into ACLK; pclk is
// treated as data and its rising edge is detected in the ACLK domain. Completed
// RGB565 pixels are decimated by 2**DEC_SHIFT in both directions and written into
// a FB_W x FB_H RAM. The read side returns a formatted 8-bit channel for the
// pixel at (xLoc, yLoc) with a fixed two-cycle latency.
//
// Optional feature: define OV_CAP_TESTPAT_EN to add the tp_en input, which
// replaces the written pixel data with a coordinate-derived test pattern.
//
// DEC_SHIFT must be at least 1.

module ov_frame_capture #(
  parameter int FB_W      = 160,
  parameter int FB_H      = 120,
  parameter int DEC_SHIFT = 2
) (
  input  logic       ACLK,
  input  logic       ARESETN,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_href,
  input  logic [7:0] cam_data,
  input  logic       capture_en,
  input  logic [9:0] xLoc,
  input  logic [9:0] yLoc,
  input  logic [1:0] output_sel,
`ifdef OV_CAP_TESTPAT_EN
  input  logic       tp_en,
`endif
  output logic [7:0] pixel_out,
  output logic       active_pixel,
  output logic       frame_done
);

  localparam int NPIX = FB_W * FB_H;
  localparam int AW   = $clog2(NPIX);
  // Camera column/row counters; 11 bits covers 640x480 with headroom, and they
  // saturate so an over-long line or frame can never wrap back into the buffer.
  localparam int CW   = 11;

  localparam logic [CW-1:0] FB_W_C = CW'(FB_W);
  localparam logic [CW-1:0] FB_H_C = CW'(FB_H);
  localparam logic [9:0]    RD_W_C = 10'(FB_W);
  localparam logic [9:0]    RD_H_C = 10'(FB_H);

  // Capture FSM encoding
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_CAPTURE  = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  // ---------------------------------------------------------------------------
  // Camera pin synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic [1:0] pclk_sync;
  logic [1:0] vsync_sync;
  logic [1:0] href_sync;
  logic [7:0] data_s1;
  logic [7:0] data_s2;
  logic       pclk_prev;
  logic       vsync_prev;
  logic       href_prev;

  // Two-flop synchronisers plus one history flop per control pin for edge detection
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      href_sync  <= '0;
      data_s1    <= '0;
      data_s2    <= '0;
      pclk_prev  <= 1'b0;
      vsync_prev <= 1'b0;
      href_prev  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage sample the previous
      // stage's old value, which is what turns these lines into a shift chain.
      pclk_sync  <= {pclk_sync[0], cam_pclk};
      vsync_sync <= {vsync_sync[0], cam_vsync};
      href_sync  <= {href_sync[0], cam_href};
      data_s1    <= cam_data;
      data_s2    <= data_s1;
      pclk_prev  <= pclk_sync[1];
      vsync_prev <= vsync_sync[1];
      href_prev  <= href_sync[1];
    end
  end

  // Data travels through the same two-stage delay as pclk, so data_s2 is the
  // byte that was on the bus at the camera's rising pclk edge.
  logic pclk_rise;
  logic vsync_rise;
  logic vsync_fall;
  logic href_fall;
  logic href_now;

  assign pclk_rise  = pclk_sync[1] & ~pclk_prev;
  assign vsync_rise = vsync_sync[1] & ~vsync_prev;
  assign vsync_fall = ~vsync_sync[1] & vsync_prev;
  assign href_fall  = ~href_sync[1] & href_prev;
  assign href_now   = href_sync[1];

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  logic [1:0] state;
  logic [1:0] state_next;

  // Next-state decode; losing capture_en aborts from any state
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (!capture_en) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:     if (vsync_rise) state_next = ST_WAIT_SOF;
        ST_WAIT_SOF: if (vsync_fall) state_next = ST_CAPTURE;
        ST_CAPTURE:  if (vsync_rise) state_next = ST_DONE;
        ST_DONE:     state_next = ST_WAIT_SOF;
        default:     state_next = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= state_next;
  end

  // DONE is a single-cycle state, so this is a one-cycle pulse per stored frame.
  assign frame_done = (state == ST_DONE);

  // ---------------------------------------------------------------------------
  // Pixel assembly and decimation
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          phase;
  logic [7:0]    hi_byte;

  logic [CW-1:0] fx;
  logic [CW-1:0] fy;
  logic          keep;
  logic [15:0]   new_pixel;

  // Frame-buffer coordinates of the pixel being completed, and whether it survives decimation
  always_comb begin
    fx        = col >> DEC_SHIFT;
    fy        = row >> DEC_SHIFT;
    keep      = (col[DEC_SHIFT-1:0] == '0) && (row[DEC_SHIFT-1:0] == '0) &&
                (fx < FB_W_C) && (fy < FB_H_C);
`ifdef OV_CAP_TESTPAT_EN
    new_pixel = tp_en ? {fx[4:0], fy[5:0], fx[4:0] ^ fy[4:0]} : {hi_byte, data_s2};
`else
    new_pixel = {hi_byte, data_s2};
`endif
  end

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;

  // Byte pairing, column/row tracking and the registered write request
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      col     <= '0;
      row     <= '0;
      phase   <= 1'b0;
      hi_byte <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state != ST_CAPTURE) begin
        // Every frame starts from the top-left corner in the high-byte phase.
        col   <= '0;
        row   <= '0;
        phase <= 1'b0;
      end else if (href_fall) begin
        // End of line: a dangling high byte from an odd-length line is dropped here.
        col   <= '0;
        phase <= 1'b0;
        if (row != '1) row <= row + 1'b1;
      end else if (pclk_rise && href_now) begin
        if (!phase) begin
          hi_byte <= data_s2;
          phase   <= 1'b1;
        end else begin
          phase   <= 1'b0;
          wr_en   <= keep;
          wr_addr <= AW'(32'(fx) + 32'(fy) * FB_W);
          wr_data <= new_pixel;
          if (col != '1) col <= col + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame RAM and read pipeline
  // ---------------------------------------------------------------------------
  logic [15:0]   frame_mem [NPIX];
  logic          rd_in_range;
  logic [AW-1:0] rd_addr;
  logic [15:0]   rd_data;

  // Out-of-range reads are steered to address 0; their result is masked later.
  always_comb begin
    rd_in_range = (xLoc < RD_W_C) && (yLoc < RD_H_C);
    rd_addr     = rd_in_range ? AW'(32'(xLoc) + 32'(yLoc) * FB_W) : '0;
  end

  // Simple dual-port RAM; a same-address read in the write cycle returns the old word
  always_ff @(posedge ACLK) begin
    // NOTE: the RAM array has no reset branch so it maps onto block RAM; its
    // contents survive ARESETN and are only defined once a frame has written them.
    if (wr_en) frame_mem[wr_addr] <= wr_data;
    rd_data <= frame_mem[rd_addr];
  end

  logic       rd_valid;
  logic [1:0] rd_sel;

  // Read-stage qualifiers travelling alongside the RAM output
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
    end else begin
      rd_valid <= rd_in_range;
      rd_sel   <= output_sel;
    end
  end

  logic [7:0] r8;
  logic [7:0] g8;
  logic [7:0] b8;
  logic [9:0] gray_sum;
  logic [7:0] fmt_pixel;

  // Expand RGB565 channels to 8 bits by replicating their MSBs, then pick the requested view
  always_comb begin
    r8       = {rd_data[15:11], rd_data[15:13]};
    g8       = {rd_data[10:5],  rd_data[10:9]};
    b8       = {rd_data[4:0],   rd_data[4:2]};
    gray_sum = {2'b00, r8} + {1'b0, g8, 1'b0} + {2'b00, b8};
    case (rd_sel)
      2'd0:    fmt_pixel = gray_sum[9:2];
      2'd1:    fmt_pixel = r8;
      2'd2:    fmt_pixel = g8;
      default: fmt_pixel = b8;
    endcase
  end

  // Output register; pixels outside the buffer read as zero
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pixel_out    <= '0;
      active_pixel <= 1'b0;
    end else begin
      pixel_out    <= rd_valid ? fmt_pixel : 8'h00;
      active_pixel <= rd_valid;
    end
  end

endmodule
